// File: rtl/sb_bus_master_if.sv
// sb_bus_master_if: client command/data channel and SB bus signals of one bus master
interface sb_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        done_err;
  logic        sb_busreq;
  logic        sb_grant;
  logic        sb_mastlock;
  logic [31:0] sb_addr;
  logic        sb_write;
  logic [1:0]  sb_trans;
  logic [2:0]  sb_size;
  logic [2:0]  sb_burst;
  logic [31:0] sb_wdata;
  logic        sb_ready;
  logic [1:0]  sb_resp;
  logic [31:0] sb_rdata;
  logic [1:0]  sb_split;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
           sb_grant, sb_ready, sb_resp, sb_rdata, sb_split,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, done_err,
           sb_busreq, sb_mastlock, sb_addr, sb_write, sb_trans, sb_size,
           sb_burst, sb_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
           sb_grant, sb_ready, sb_resp, sb_rdata, sb_split,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, done_err,
           sb_busreq, sb_mastlock, sb_addr, sb_write, sb_trans, sb_size,
           sb_burst, sb_wdata
  );
endinterface

// File: rtl/sb_bus_master.sv
// sb_bus_master: SB bus initiator running one 1..16 word burst per client command with split resume
module sb_bus_master #(
  parameter int MASTER_ID     = 0,
  parameter int READY_TIMEOUT = 64,
  parameter int SPLIT_TIMEOUT = 256
) (
  input  logic          sb_clk,
  input  logic          sb_resetn,
  sb_bus_master_if.master bus
);
  localparam int RW = $clog2(READY_TIMEOUT + 1);
  localparam int SW = $clog2(SPLIT_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, XFER, SPLIT_WAIT, DONE} state_t;

  state_t        state, state_n;
  logic          err_q, err_n;
  logic          write_q, first_q, have_q, rdv_q;
  logic [31:0]   addr_q, wdata_q, rd_q;
  logic [4:0]    len_q, beat_cnt, rem;
  logic [RW-1:0] rdy_cnt;
  logic [SW-1:0] spl_cnt;
  logic          xfer, accept, bad_len, active, wr_take;
  logic          beat_ok, err_hit, split_hit, last, rdy_to, spl_to;

  assign xfer      = state == XFER;
  assign accept    = state == IDLE && bus.cmd_valid;
  assign bad_len   = bus.cmd_len == 5'd0 || bus.cmd_len > 5'd16;
  // a write beat is only presented once its data word is held or arriving this cycle
  assign active    = xfer && bus.sb_grant && (!write_q || have_q || bus.wr_valid);
  assign wr_take   = xfer && bus.sb_grant && write_q && !have_q && bus.wr_valid;
  assign beat_ok   = active && bus.sb_ready && bus.sb_resp == 2'd1;
  assign err_hit   = active && bus.sb_ready && bus.sb_resp == 2'd2;
  assign split_hit = active && bus.sb_ready && bus.sb_resp == 2'd3;
  assign last      = beat_cnt + 5'd1 == len_q;
  assign rdy_to    = !bus.sb_ready && rdy_cnt == RW'(READY_TIMEOUT - 1);
  assign spl_to    = spl_cnt == SW'(SPLIT_TIMEOUT - 1);
  assign rem       = len_q - beat_cnt;

  assign bus.cmd_ready   = state == IDLE;
  assign bus.wr_ready    = wr_take;
  assign bus.rd_data     = rd_q;
  assign bus.rd_valid    = rdv_q;
  assign bus.done        = state == DONE;
  assign bus.done_err    = state == DONE && err_q;
  assign bus.sb_busreq   = state == REQ || xfer;
  assign bus.sb_mastlock = xfer;
  assign bus.sb_addr     = addr_q;
  assign bus.sb_write    = xfer && write_q;
  assign bus.sb_trans    = (!xfer || !bus.sb_grant) ? 2'd0 : !active ? 2'd1 : first_q ? 2'd2 : 2'd3;
  assign bus.sb_size     = 3'b010;
  assign bus.sb_burst    = !xfer ? 3'd0 : rem <= 5'd1 ? 3'd0 : rem <= 5'd2 ? 3'd1 :
                           rem <= 5'd4 ? 3'd2 : rem <= 5'd8 ? 3'd3 : 3'd4;
  assign bus.sb_wdata    = (xfer && write_q && !have_q) ? bus.wr_data : wdata_q;

  // state register
  always_ff @(posedge sb_clk or negedge sb_resetn)
    if (!sb_resetn) state <= IDLE;
    else state <= state_n;

  // next-state logic; err_n records why a burst ended when entering DONE
  always_comb begin
    state_n = state;
    err_n   = err_q;
    case (state)
      IDLE:       if (accept) begin state_n = bad_len ? DONE : REQ; err_n = bad_len; end
      REQ:        if (bus.sb_grant) state_n = XFER;
      XFER:       if (!bus.sb_grant) state_n = REQ;
                  else if (beat_ok && last) begin state_n = DONE; err_n = 1'b0; end
                  else if (err_hit || rdy_to) begin state_n = DONE; err_n = 1'b1; end
                  else if (split_hit) state_n = SPLIT_WAIT;
      SPLIT_WAIT: if (bus.sb_split[MASTER_ID]) state_n = REQ;
                  else if (spl_to) begin state_n = DONE; err_n = 1'b1; end
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // burst datapath: address/beat progress, held write word, read return and timeout counters
  always_ff @(posedge sb_clk or negedge sb_resetn)
    if (!sb_resetn) begin
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      first_q  <= 1'b0;
      have_q   <= 1'b0;
      rdv_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      rdy_cnt  <= '0;
      spl_cnt  <= '0;
    end else begin
      err_q <= err_n;
      if (accept) begin
        write_q  <= bus.cmd_write;
        addr_q   <= bus.cmd_addr;
        len_q    <= bus.cmd_len;
        beat_cnt <= '0;
      end
      if (state == REQ) first_q <= 1'b1;
      if (beat_ok) begin
        beat_cnt <= beat_cnt + 5'd1;
        addr_q   <= addr_q + 32'd1;
        first_q  <= 1'b0;
      end
      if (wr_take) wdata_q <= bus.wr_data;
      have_q <= (accept || beat_ok || err_hit) ? 1'b0 : wr_take ? 1'b1 : have_q;
      rdv_q  <= beat_ok && !write_q;
      if (beat_ok && !write_q) rd_q <= bus.sb_rdata;
      rdy_cnt <= (xfer && !bus.sb_ready) ? (rdy_cnt == RW'(READY_TIMEOUT) ? rdy_cnt : rdy_cnt + RW'(1)) : '0;
      spl_cnt <= (state == SPLIT_WAIT) ? (spl_cnt == SW'(SPLIT_TIMEOUT) ? spl_cnt : spl_cnt + SW'(1)) : '0;
    end
endmodule

// File: tb/tb_sb_bus_master.sv
// tb_sb_bus_master: directed scenarios for the SB bus master with a scripted slave/arbiter
module tb_sb_bus_master;
  localparam int ID = 1;

  logic sb_clk = 1'b0;
  logic sb_resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sb_bus_master_if bus();

  sb_bus_master #(.MASTER_ID(ID)) dut (
    .sb_clk(sb_clk),
    .sb_resetn(sb_resetn),
    .bus(bus)
  );

  always #5 sb_clk = ~sb_clk;

  int          n_beats, n_rd, n_busy, n_lock, n_split_req, wr_idx;
  logic [31:0] b_addr[32];
  logic [31:0] b_wdata[32];
  logic [31:0] r_data[32];
  logic [1:0]  b_trans[32];
  logic [2:0]  b_burst[32];
  bit          saw_done, got_err, saw_busreq;

  int          split_at, split_wait, err_at, busy_at, busy_n;
  bit          never_ready;
  logic [31:0] wbase;

  task automatic clear_cfg();
    split_at = -1; split_wait = 0; err_at = -1; busy_at = -1; busy_n = 0;
    never_ready = 0; wbase = 32'h0;
  endtask

  // issue one command and play arbiter/slave/client until done or the cycle budget runs out
  task automatic run_burst(input logic wr, input logic [31:0] addr, input logic [4:0] len, input int budget);
    int split_cnt = 0;
    int busy_left = busy_n;
    bit in_split = 0;
    bit split_done = 0;
    bit pulse;
    n_beats = 0; n_rd = 0; n_busy = 0; n_lock = 0; n_split_req = 0; wr_idx = 0;
    saw_done = 0; got_err = 0; saw_busreq = 0;
    @(negedge sb_clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_len = len;
    for (int c = 0; c < budget; c++) begin
      if (c > 0) begin
        @(negedge sb_clk);
        bus.cmd_valid = 1'b0;
      end
      pulse = 0;
      if (in_split) begin
        split_cnt++;
        pulse = split_cnt == split_wait;
      end
      bus.sb_split = 2'b00;
      bus.sb_split[ID] = pulse;
      bus.sb_grant = bus.sb_busreq;
      bus.wr_valid = !(bus.sb_mastlock && wr_idx == busy_at && busy_left > 0);
      bus.wr_data = wbase + 32'(wr_idx);
      #1;
      bus.sb_ready = 1'b0; bus.sb_resp = 2'd0; bus.sb_rdata = 32'h0;
      if (bus.sb_trans == 2'd1) begin
        bus.sb_ready = 1'b1; bus.sb_resp = 2'd1;
      end else if (bus.sb_trans[1] && !never_ready) begin
        bus.sb_ready = 1'b1;
        bus.sb_resp = (n_beats == err_at) ? 2'd2 : (n_beats == split_at && !split_done) ? 2'd3 : 2'd1;
        bus.sb_rdata = 32'hD000_0000 + bus.sb_addr;
      end
      #1;
      if (bus.sb_busreq) saw_busreq = 1;
      if (bus.sb_mastlock) n_lock++;
      if (in_split && bus.sb_busreq) n_split_req++;
      if (bus.sb_trans == 2'd1) n_busy++;
      if (!bus.wr_valid) busy_left--;
      if (bus.wr_ready) wr_idx++;
      if (bus.sb_ready && bus.sb_trans[1] && bus.sb_resp == 2'd1) begin
        b_addr[n_beats] = bus.sb_addr; b_wdata[n_beats] = bus.sb_wdata;
        b_trans[n_beats] = bus.sb_trans; b_burst[n_beats] = bus.sb_burst;
        n_beats++;
      end
      if (bus.sb_ready && bus.sb_trans[1] && bus.sb_resp == 2'd3) begin
        in_split = 1; split_done = 1;
      end
      if (pulse) in_split = 0;
      if (bus.rd_valid) begin
        r_data[n_rd] = bus.rd_data;
        n_rd++;
      end
      if (bus.done) begin
        saw_done = 1; got_err = bus.done_err;
        break;
      end
    end
    bus.cmd_valid = 1'b0; bus.sb_grant = 1'b0; bus.sb_ready = 1'b0; bus.sb_resp = 2'd0;
    bus.wr_valid = 1'b0; bus.sb_split = 2'b00;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if (bus.sb_busreq !== 1'b0 || bus.sb_mastlock !== 1'b0 || bus.sb_write !== 1'b0) begin errors++; $display("FAIL reset_bus_ctrl: got busreq=%b lock=%b write=%b expected 0/0/0", bus.sb_busreq, bus.sb_mastlock, bus.sb_write); end
    checks++; if (bus.sb_trans !== 2'd0 || bus.sb_burst !== 3'd0 || bus.sb_size !== 3'b010) begin errors++; $display("FAIL reset_trans: got trans=%0d burst=%0d size=%0d expected 0/0/2", bus.sb_trans, bus.sb_burst, bus.sb_size); end
    checks++; if (bus.sb_addr !== 32'h0 || bus.sb_wdata !== 32'h0 || bus.rd_data !== 32'h0) begin errors++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected 0", bus.sb_addr, bus.sb_wdata, bus.rd_data); end
    checks++; if (bus.done !== 1'b0 || bus.done_err !== 1'b0 || bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b err=%b rdv=%b wrr=%b expected 0", bus.done, bus.done_err, bus.rd_valid, bus.wr_ready); end
    @(negedge sb_clk);
    sb_resetn = 1'b1;
  endtask

  task automatic test_single_write();
    clear_cfg(); wbase = 32'hA5A5_A5A5;
    run_burst(1'b1, 32'h10, 5'd1, 20);
    checks++; if (!saw_done || got_err) begin errors++; $display("FAIL wr1_done: got done=%b err=%b expected 1/0", saw_done, got_err); end
    checks++; if (n_beats !== 1) begin errors++; $display("FAIL wr1_beats: got %0d expected 1", n_beats); end
    checks++; if (b_addr[0] !== 32'h10 || b_trans[0] !== 2'd2 || b_burst[0] !== 3'd0) begin errors++; $display("FAIL wr1_beat: got addr=%h trans=%0d burst=%0d expected 10/2/0", b_addr[0], b_trans[0], b_burst[0]); end
    checks++; if (b_wdata[0] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wr1_data: got %h expected a5a5a5a5", b_wdata[0]); end
    @(negedge sb_clk); #1;
    checks++; if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL wr1_idle: got cmd_ready=%b done=%b expected 1/0", bus.cmd_ready, bus.done); end
  endtask

  task automatic test_read_burst();
    clear_cfg();
    run_burst(1'b0, 32'h100, 5'd8, 40);
    checks++; if (!saw_done || got_err) begin errors++; $display("FAIL rd8_done: got done=%b err=%b expected 1/0", saw_done, got_err); end
    checks++; if (n_beats !== 8 || n_rd !== 8) begin errors++; $display("FAIL rd8_count: got beats=%0d rd_valid=%0d expected 8/8", n_beats, n_rd); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (b_addr[i] !== 32'h100 + 32'(i) || b_trans[i] !== (i == 0 ? 2'd2 : 2'd3)) begin errors++; $display("FAIL rd8_beat%0d: got addr=%h trans=%0d expected %h/%0d", i, b_addr[i], b_trans[i], 32'h100 + 32'(i), i == 0 ? 2 : 3); end
      checks++; if (r_data[i] !== 32'hD000_0100 + 32'(i)) begin errors++; $display("FAIL rd8_data%0d: got %h expected %h", i, r_data[i], 32'hD000_0100 + 32'(i)); end
    end
    checks++; if (b_burst[0] !== 3'd3 || b_burst[4] !== 3'd2 || b_burst[6] !== 3'd1 || b_burst[7] !== 3'd0) begin errors++; $display("FAIL rd8_burst: got %0d/%0d/%0d/%0d expected 3/2/1/0", b_burst[0], b_burst[4], b_burst[6], b_burst[7]); end
  endtask

  task automatic test_write_busy();
    clear_cfg(); wbase = 32'h3000_0000; busy_at = 2; busy_n = 2;
    run_burst(1'b1, 32'h200, 5'd4, 40);
    checks++; if (!saw_done || got_err) begin errors++; $display("FAIL busy_done: got done=%b err=%b expected 1/0", saw_done, got_err); end
    checks++; if (n_busy !== 2) begin errors++; $display("FAIL busy_cycles: got %0d expected 2", n_busy); end
    checks++; if (n_beats !== 4 || wr_idx !== 4) begin errors++; $display("FAIL busy_count: got beats=%0d taken=%0d expected 4/4", n_beats, wr_idx); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_wdata[i] !== 32'h3000_0000 + 32'(i) || b_addr[i] !== 32'h200 + 32'(i)) begin errors++; $display("FAIL busy_beat%0d: got data=%h addr=%h expected %h/%h", i, b_wdata[i], b_addr[i], 32'h3000_0000 + 32'(i), 32'h200 + 32'(i)); end
    end
    checks++; if (b_burst[0] !== 3'd2 || b_trans[2] !== 2'd3) begin errors++; $display("FAIL busy_ctrl: got burst0=%0d trans2=%0d expected 2/3", b_burst[0], b_trans[2]); end
  endtask

  task automatic test_split();
    clear_cfg(); wbase = 32'h4000_0000; split_at = 2; split_wait = 10;
    run_burst(1'b1, 32'h400, 5'd8, 80);
    checks++; if (!saw_done || got_err) begin errors++; $display("FAIL split_done: got done=%b err=%b expected 1/0", saw_done, got_err); end
    checks++; if (n_beats !== 8 || wr_idx !== 8) begin errors++; $display("FAIL split_count: got beats=%0d taken=%0d expected 8/8", n_beats, wr_idx); end
    checks++; if (n_split_req !== 0) begin errors++; $display("FAIL split_busreq: got %0d busreq cycles expected 0", n_split_req); end
    checks++; if (b_addr[2] !== 32'h402 || b_trans[2] !== 2'd2 || b_trans[3] !== 2'd3 || b_burst[2] !== 3'd3) begin errors++; $display("FAIL split_resume: got addr=%h trans=%0d next=%0d burst=%0d expected 402/2/3/3", b_addr[2], b_trans[2], b_trans[3], b_burst[2]); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (b_wdata[i] !== 32'h4000_0000 + 32'(i) || b_addr[i] !== 32'h400 + 32'(i)) begin errors++; $display("FAIL split_beat%0d: got data=%h addr=%h expected %h/%h", i, b_wdata[i], b_addr[i], 32'h4000_0000 + 32'(i), 32'h400 + 32'(i)); end
    end
  endtask

  task automatic test_error();
    clear_cfg(); err_at = 1;
    run_burst(1'b0, 32'h300, 5'd4, 30);
    checks++; if (!saw_done || !got_err) begin errors++; $display("FAIL err_done: got done=%b err=%b expected 1/1", saw_done, got_err); end
    checks++; if (n_rd !== 1 || r_data[0] !== 32'hD000_0300) begin errors++; $display("FAIL err_reads: got count=%0d data=%h expected 1/d0000300", n_rd, r_data[0]); end
    clear_cfg();
    run_burst(1'b0, 32'h0, 5'd0, 6);
    checks++; if (!saw_done || !got_err) begin errors++; $display("FAIL len0_done: got done=%b err=%b expected 1/1", saw_done, got_err); end
    checks++; if (saw_busreq) begin errors++; $display("FAIL len0_busreq: got %b expected 0", saw_busreq); end
    clear_cfg();
    run_burst(1'b1, 32'h0, 5'd17, 6);
    checks++; if (!saw_done || !got_err || saw_busreq) begin errors++; $display("FAIL len17: got done=%b err=%b busreq=%b expected 1/1/0", saw_done, got_err, saw_busreq); end
  endtask

  task automatic test_timeout_reset();
    clear_cfg(); never_ready = 1;
    run_burst(1'b0, 32'h500, 5'd2, 120);
    checks++; if (!saw_done || !got_err) begin errors++; $display("FAIL tmo_done: got done=%b err=%b expected 1/1", saw_done, got_err); end
    checks++; if (n_lock !== 64 || n_rd !== 0) begin errors++; $display("FAIL tmo_cycles: got xfer=%0d reads=%0d expected 64/0", n_lock, n_rd); end
    clear_cfg(); never_ready = 1;
    run_burst(1'b0, 32'h600, 5'd8, 8);
    #1;
    checks++; if (bus.sb_mastlock !== 1'b1 || bus.sb_addr !== 32'h600) begin errors++; $display("FAIL rst_pre: got lock=%b addr=%h expected 1/600", bus.sb_mastlock, bus.sb_addr); end
    sb_resetn = 1'b0;
    #1;
    checks++; if (bus.sb_busreq !== 1'b0 || bus.sb_mastlock !== 1'b0 || bus.sb_trans !== 2'd0) begin errors++; $display("FAIL rst_bus: got busreq=%b lock=%b trans=%0d expected 0/0/0", bus.sb_busreq, bus.sb_mastlock, bus.sb_trans); end
    checks++; if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.sb_addr !== 32'h0 || bus.sb_burst !== 3'd0) begin errors++; $display("FAIL rst_state: got cmd_ready=%b done=%b addr=%h burst=%0d expected 1/0/0/0", bus.cmd_ready, bus.done, bus.sb_addr, bus.sb_burst); end
    @(negedge sb_clk);
    sb_resetn = 1'b1;
    @(negedge sb_clk); #1;
    checks++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_after: got done=%b cmd_ready=%b expected 0/1", bus.done, bus.cmd_ready); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_len = 5'd0;
    bus.wr_data = 32'h0; bus.wr_valid = 1'b0; bus.sb_grant = 1'b0; bus.sb_ready = 1'b0;
    bus.sb_resp = 2'd0; bus.sb_rdata = 32'h0; bus.sb_split = 2'b00;
    clear_cfg();
    repeat (2) @(negedge sb_clk);
    test_reset();
    test_single_write();
    test_read_burst();
    test_write_busy();
    test_split();
    test_error();
    test_timeout_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
